// File: rtl/nib_seq_mul_ctrl.sv
// nib_seq_mul_ctrl
// ----------------
// Sequential control and accumulate stage of the nibble-serial 8x8
// multiplier. The block steers the select lines of two external nibble
// muxes and forms one NIB_W x NIB_W partial product per cycle. It
// shift-accumulates the four partial products into a 4*NIB_W result.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a multiply; sampled only in IDLE
//   a_nib      in   NIB_W nibble from the operand-A mux (combinational in a_sel)
//   b_nib      in   NIB_W nibble from the operand-B mux (combinational in b_sel)
//   a_sel      out  A mux select, 0 = low nibble, 1 = high nibble
//   b_sel      out  B mux select, 0 = low nibble, 1 = high nibble
//   busy       out  high while a multiply is in progress (MUL state)
//   done       out  one-cycle pulse in the cycle the new product is visible
//   product    out  registered result, held until the next completion
//   state_dbg  out  current FSM state encoding (0 IDLE, 1 MUL, 2 DONE)
//
// Handshake: start is a request that is honoured only on an edge where the
// block is IDLE. It is ignored while busy or done is high, and it is never
// queued. After an accepted start, busy is high for exactly four cycles.
// done then pulses for one cycle together with the updated product. If
// start is held high, a new operation is accepted every six cycles.
module nib_seq_mul_ctrl #(
  parameter int NIB_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NIB_W-1:0]   a_nib,
  input  logic [NIB_W-1:0]   b_nib,
  output logic               a_sel,
  output logic               b_sel,
  output logic               busy,
  output logic               done,
  output logic [4*NIB_W-1:0] product,
  output logic [1:0]         state_dbg
);

  localparam int PW = 4 * NIB_W;
  localparam int OW = 2 * NIB_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [OW-1:0]   pp;
  logic [PW-1:0]   pp_ext;
  logic [PW-1:0]   term;
  logic [PW-1:0]   sum;

  // Partial product of the nibbles currently presented by the muxes.
  // The shift is NIB_W times the number of high nibbles selected.
  // Because the selects are step[0] and step[1], the shift is decoded from step.
  always_comb begin
    pp     = {{NIB_W{1'b0}}, a_nib} * {{NIB_W{1'b0}}, b_nib};
    pp_ext = {{(PW-OW){1'b0}}, pp};
    case (step_q)
      2'd0:    term = pp_ext;
      2'd3:    term = pp_ext << (2 * NIB_W);
      default: term = pp_ext << NIB_W;
    endcase
    sum = acc_q + term;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = sum;
        if (step_q == 2'd3) begin
          // Take the combinational sum so the final term is included.
          prod_d  = sum;
          step_d  = 2'd0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // step is 0 in both IDLE and DONE, so both selects are 0 in those states.
  assign a_sel     = step_q[0];
  assign b_sel     = step_q[1];
  assign busy      = (state_q == S_MUL);
  assign done      = (state_q == S_DONE);
  assign product   = prod_q;
  assign state_dbg = state_q;

endmodule

// File: doc/nib_seq_mul_ctrl.md
Name: nib_seq_mul_ctrl

Overview:
- Sequential control and accumulate stage of the 8x8 multiplier. It consumes the 4-bit outputs of the two nibble muxes (operand A and operand B).
- Drives each mux's select line and forms one 4x4 partial product per cycle.
- Shift-accumulates the partial products into a 16-bit result, with a start/busy/done handshake toward the issuing logic.

Parameters:
- NIB_W, 4, nibble width. Operand width is 2*NIB_W; product width is 4*NIB_W. Only 4 is verified.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- a_nib  input  NIB_W  nibble from the operand-A mux (combinational function of a_sel).
- b_nib  input  NIB_W  nibble from the operand-B mux (combinational function of b_sel).
- a_sel  output  1  select for the A mux. 0 = low nibble, 1 = high nibble.
- b_sel  output  1  select for the B mux. 0 = low nibble, 1 = high nibble.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when the product is updated.
- product  output  4*NIB_W  registered result. Held until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, step = 0, acc = 0.
  - a_sel = 0, b_sel = 0, busy = 0, done = 0, product = 0.
- States: IDLE, MUL, DONE.
- IDLE:
  - a_sel = b_sel = 0, busy = 0.
  - On an edge with start = 1: acc <= 0, step <= 0, go to MUL.
- MUL:
  - busy = 1.
  - 2-bit step counter; a_sel = step[0], b_sel = step[1], all registered.
  - Step order:
    - step 0: A lo x B lo, shift 0.
    - step 1: A hi x B lo, shift NIB_W.
    - step 2: A lo x B hi, shift NIB_W.
    - step 3: A hi x B hi, shift 2*NIB_W.
  - Each edge: acc <= acc + ((a_nib * b_nib) << (NIB_W*(a_sel+b_sel))).
    - Unsigned arithmetic.
    - The partial product is 2*NIB_W bits, zero-extended to 4*NIB_W.
    - No overflow is possible (max 0xFF*0xFF = 0xFE01).
  - The mux path is combinational: a_nib and b_nib are sampled in the same cycle their select is presented.
  - At the step-3 edge:
    - product <= final sum (acc + last term, computed combinationally, not the stale acc).
    - done <= 1, go to DONE, step wraps to 0.
- DONE:
  - busy = 0, done = 1 for exactly this cycle, sels = 0.
  - Next edge: go to IDLE, done <= 0.
- Latency: start sampled at edge E0. Steps accumulate at E1..E4. done and the new product are visible after E4, so done is asserted 4 cycles after the start edge. Issue interval is 6 cycles.
- start while busy, or while in DONE: ignored. No queuing, no effect on acc or sels.
- Operands: upstream holds both 8-bit mux inputs stable from the start edge through the last MUL cycle. Changes during busy corrupt the result; this is not detected.
- product changes only at the completion edge or reset. It is stable during a subsequent operation.
- Reset mid-operation: immediate return to IDLE. All outputs go to their reset values, including product = 0. No done pulse.
- start held high continuously: a new operation begins at each IDLE edge. Back-to-back results arrive every 6 cycles.

Test Plan:
- Reset, then A = 0x12, B = 0x34, pulse start -> sels step (0,0), (1,0), (0,1), (1,1) on consecutive cycles; busy high for 4 cycles; done pulses once; product = 0x03A8.
- A = 0xFF, B = 0xFF -> product = 0xFE01 exactly 4 cycles after the start edge; no wrap.
- A = 0x00, B = 0xAB, then A = 0x80, B = 0x02 back-to-back (start held high) -> product 0x0000, then 0x0100; second done pulse 6 cycles after the first.
- Pulse start during cycles 2 and 3 of a busy operation (A = 0x0F, B = 0x10) -> single done pulse, product = 0x00F0; no extra operation launched.
- Assert rst_n low during step 2 of a multiply whose previous product was 0x03A8 -> busy, done, sels and product all 0 immediately (asynchronous); no done pulse after release; a fresh multiply of 0x03 x 0x05 then yields 0x000F.
